// File: rtl/fmap_zero_pad_stream.sv
// Streaming zero-padding stage: wraps an IMG_W x IMG_H fp32 plane with a PAD-wide
// border of PAD_VALUE words, emitting the padded plane row-major through one output register.
module fmap_zero_pad_stream #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    IMG_W      = 8,
  parameter int                    IMG_H      = 8,
  parameter int                    PAD        = 1,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  out_is_pad,
  output logic                  busy,
  output logic                  done
);

  localparam int OUT_W = IMG_W + 2 * PAD;
  localparam int OUT_H = IMG_H + 2 * PAD;
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] ocol;
  logic [RW-1:0] orow;
  logic          interior;
  logic          at_last;
  logic          ld;
  logic          advance;
  logic          out_hs;

  always_comb begin
    interior = (int'(orow) >= PAD) && (int'(orow) < PAD + IMG_H) &&
               (int'(ocol) >= PAD) && (int'(ocol) < PAD + IMG_W);
  end

  assign at_last  = (orow == ROW_LAST) && (ocol == COL_LAST);
  assign ld       = (state == RUN) && (!out_valid || out_ready);
  assign in_ready = ld && interior;
  // Border words never wait on the producer; interior ones only move with in_valid.
  assign advance  = ld && (!interior || in_valid);
  assign out_hs   = out_valid && out_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (advance && at_last) state_nxt = DRAIN;
      DRAIN:   if (out_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ocol       <= '0;
      orow       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_is_pad <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == DRAIN) && out_hs;
      if (ld) begin
        if (advance) begin
          out_valid  <= 1'b1;
          out_data   <= interior ? in_data : PAD_VALUE;
          out_is_pad <= !interior;
          out_last   <= at_last;
          if (at_last) begin
            ocol <= '0;
            orow <= '0;
          end else if (ocol == COL_LAST) begin
            ocol <= '0;
            orow <= orow + RW'(1);
          end else begin
            ocol <= ocol + CW'(1);
          end
        end else begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fmap_zero_pad_stream.sv
// Directed bench: a 2x2 plane padded by 1 (16-word output) under various handshake
// patterns, plus a PAD=0 3x1 pass-through instance.
module tb_fmap_zero_pad_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid, in_ready, out_valid, out_ready, out_last, out_is_pad, busy, done;
  logic [31:0] in_data, out_data;
  logic        start0, in_valid0, in_ready0, out_valid0, out_ready0, out_last0, out_is_pad0, busy0, done0;
  logic [31:0] in_data0, out_data0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] in_words [4];
  logic [31:0] exp_data [16];
  logic        exp_pad  [16];

  always #5 clk = ~clk;

  fmap_zero_pad_stream #(.DATA_WIDTH(32), .IMG_W(2), .IMG_H(2), .PAD(1), .PAD_VALUE(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_is_pad(out_is_pad), .busy(busy), .done(done)
  );

  fmap_zero_pad_stream #(.DATA_WIDTH(32), .IMG_W(3), .IMG_H(1), .PAD(0), .PAD_VALUE(32'h0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_last(out_last0), .out_is_pad(out_is_pad0), .busy(busy0), .done(done0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, expv, $time);
    end
  endtask

  // One 16-word plane on the padded instance; inputs change on the falling edge.
  task automatic applyStimulus(input bit do_start, input bit toggle_ready, input int gap_len,
                               input int abort_at, input bit spam_start, input bit chain_next,
                               input int exp_ready_cycles, input int exp_bubbles);
    int       o_idx = 0, i_idx = 0, gap_used = 0, ready_cycles = 0, bubbles = 0;
    bit       finished = 1'b0;
    bit [3:0] ready_pat = 4'b1001;
    if (do_start) begin
      @(negedge clk);
      start = 1'b1;
    end
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (o_idx < 16) begin
          checkOutput("data", out_data, exp_data[o_idx]);
          checkOutput("is_pad", {31'b0, out_is_pad}, {31'b0, exp_pad[o_idx]});
          checkOutput("last", {31'b0, out_last}, {31'b0, (o_idx == 15)});
        end else begin
          checkOutput("extra_word", o_idx, 16);
        end
      end
      if (busy && !out_valid) bubbles++;
      if (done) finished = 1'b1;
      if (abort_at >= 0 && o_idx == abort_at) begin
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        return;
      end
      start = finished ? chain_next : (spam_start && busy);
      out_ready = toggle_ready ? ready_pat[cyc % 4] : 1'b1;
      #1;
      in_valid = 1'b0;
      if (!finished && i_idx < 4) begin
        if (i_idx == 2 && gap_used < gap_len && in_ready) begin
          gap_used++;
        end else begin
          in_valid = 1'b1;
          in_data  = in_words[i_idx];
        end
      end
      #1;
      if (in_ready) ready_cycles++;
      if (in_valid && in_ready) i_idx++;
      if (out_valid && out_ready) o_idx++;
    end
    if (!finished) begin
      checkOutput("timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("out_beats", o_idx, 16);
      checkOutput("in_beats", i_idx, 4);
      if (exp_ready_cycles >= 0) checkOutput("in_ready_cycles", ready_cycles, exp_ready_cycles);
      if (exp_bubbles >= 0) checkOutput("bubbles", bubbles, exp_bubbles);
    end
    if (!chain_next) begin
      @(negedge clk);
      start = 1'b0;
      checkOutput("done_single", {31'b0, done}, 32'd0);
      checkOutput("idle_after", {31'b0, busy}, 32'd0);
    end
  endtask

  task automatic applyPassThrough();
    int o_idx = 0, i_idx = 0;
    bit expect_next = 1'b0, finished = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    for (int cyc = 0; cyc < 50 && !finished; cyc++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (expect_next) checkOutput("p0_latency", {31'b0, out_valid0}, 32'd1);
      expect_next = 1'b0;
      if (out_valid0) begin
        checkOutput("p0_data", out_data0, o_idx + 1);
        checkOutput("p0_is_pad", {31'b0, out_is_pad0}, 32'd0);
        checkOutput("p0_last", {31'b0, out_last0}, {31'b0, (o_idx == 2)});
      end
      if (done0) finished = 1'b1;
      in_valid0  = (i_idx < 3);
      in_data0   = i_idx + 1;
      out_ready0 = 1'b1;
      #1;
      if (in_valid0 && in_ready0) begin
        i_idx++;
        expect_next = 1'b1;
      end
      if (out_valid0 && out_ready0) o_idx++;
    end
    checkOutput("p0_finished", {31'b0, finished}, 32'd1);
    checkOutput("p0_out_beats", o_idx, 3);
    in_valid0 = 1'b0;
  endtask

  initial begin
    in_words = '{32'h41900000, 32'h41900002, 32'h41900008, 32'h3F800000};
    for (int i = 0; i < 16; i++) begin
      exp_data[i] = 32'h0;
      exp_pad[i]  = 1'b1;
    end
    exp_data[5]  = in_words[0]; exp_pad[5]  = 1'b0;
    exp_data[6]  = in_words[1]; exp_pad[6]  = 1'b0;
    exp_data[9]  = in_words[2]; exp_pad[9]  = 1'b0;
    exp_data[10] = in_words[3]; exp_pad[10] = 1'b0;

    rst = 1'b1;
    start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    start0 = 1'b0; in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_out_last", {31'b0, out_last}, 32'd0);
    checkOutput("rst_out_is_pad", {31'b0, out_is_pad}, 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;

    $display("[TB] basic plane");
    applyStimulus(1'b1, 1'b0, 0, -1, 1'b0, 1'b0, 4, 1);
    $display("[TB] output back-pressure");
    applyStimulus(1'b1, 1'b1, 0, -1, 1'b0, 1'b0, -1, -1);
    $display("[TB] input bubbles");
    applyStimulus(1'b1, 1'b0, 3, -1, 1'b0, 1'b0, 7, 4);
    $display("[TB] reset mid-plane");
    applyStimulus(1'b1, 1'b0, 0, 7, 1'b0, 1'b0, -1, -1);
    applyStimulus(1'b1, 1'b0, 0, -1, 1'b0, 1'b0, 4, 1);
    $display("[TB] start spam then back-to-back plane");
    applyStimulus(1'b1, 1'b0, 0, -1, 1'b1, 1'b1, 4, 1);
    applyStimulus(1'b0, 1'b0, 0, -1, 1'b0, 1'b0, 4, 1);
    $display("[TB] PAD=0 pass-through");
    applyPassThrough();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmap_zero_pad_stream.md
Name: fmap_zero_pad_stream

Overview:
Streaming zero-padding stage for CNN feature maps (IEEE-754 single-precision words, row-major order). It accepts an IMG_W x IMG_H channel plane on a valid/ready input. It emits the padded (IMG_W+2*PAD) x (IMG_H+2*PAD) plane on a valid/ready output, inserting PAD_VALUE border words without stalling the producer for interior beats. It sits between the line-buffer/DMA read path and the convolution window generator and replaces per-word enable-based padding muxing.

Parameters:
DATA_WIDTH, 32, word width (fp32).
IMG_W, 8, input plane width in words (>=1).
IMG_H, 8, input plane height in rows (>=1).
PAD, 1, border width on each side (0..3).
PAD_VALUE, 0, word inserted at border positions (32'h0 = +0.0).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to begin a plane; honoured only in IDLE.
in_data  in  DATA_WIDTH  interior pixel word.
in_valid  in  1  in_data valid.
in_ready  out  1  block accepts in_data this cycle.
out_data  out  DATA_WIDTH  padded-stream word (registered).
out_valid  out  1  out_data valid (registered).
out_ready  in  1  consumer accepts out_data.
out_last  out  1  marks final word of the padded plane (registered, qualified by out_valid).
out_is_pad  out  1  current out_data is a border word (registered).
busy  out  1  high in RUN and DRAIN.
done  out  1  one-cycle pulse after the last word is accepted downstream.

Behaviour:
- OUT_W = IMG_W+2*PAD and OUT_H = IMG_H+2*PAD. Column counter ocol is $clog2(OUT_W) bits wide and row counter orow is $clog2(OUT_H) bits wide, with a minimum of 1 bit each.
- Reset (async assert, sync release): state=IDLE, ocol=orow=0, out_valid=0, out_last=0, out_is_pad=0, out_data=0, done=0. in_ready is therefore 0.
- Border position: orow<PAD, or orow>=PAD+IMG_H, or ocol<PAD, or ocol>=PAD+IMG_W. Every other position is interior.
- Load enable: ld = (state==RUN) & (~out_valid | out_ready). The output register is a single entry.
- in_ready = ld & interior(orow,ocol). It is combinational and has no combinational dependency on in_valid.
- On each ld cycle in RUN:
  - Border position: out_data<=PAD_VALUE, out_is_pad<=1, out_valid<=1, and the counter advances.
  - Interior position with in_valid: out_data<=in_data, out_is_pad<=0, out_valid<=1, and the counter advances.
  - Interior position without in_valid: out_valid<=0 and the counter holds (bubble).
- When not loading and out_ready=1, out_valid<=0. While out_valid=1 and out_ready=0, out_data, out_last and out_is_pad stay stable.
- Counter advance: ocol wraps from OUT_W-1 to 0 and orow then increments.
- When the loaded position is (OUT_H-1, OUT_W-1), out_last<=1 and state->DRAIN. The counters return to 0.
- FSM transitions:
  - IDLE --start--> RUN.
  - RUN --last position loaded--> DRAIN.
  - DRAIN --(out_valid & out_ready)--> IDLE, with done=1 in that same cycle (registered, asserted on the following edge for exactly one cycle).
- start in RUN or DRAIN is ignored. start is accepted in the cycle after done.
- Latency: an input accepted in cycle N appears on out_data in cycle N+1. Border words are produced at full rate (1 per cycle with out_ready=1).
- Beat counts per plane: exactly IMG_W*IMG_H input handshakes and OUT_W*OUT_H output handshakes.
- PAD=0: pure registered pass-through with out_last framing; out_is_pad is never 1.
- Reset mid-plane aborts the plane immediately. No done pulse is issued, and the partial output is discarded by the consumer.
- in_valid while IDLE/DRAIN or at a border position is not accepted (in_ready=0). Data is held by the producer.

Test Plan:
- IMG_W=IMG_H=2, PAD=1, out_ready=1, inputs 0x41900000, 0x41900002, 0x41900008, 0x3F800000 always valid -> the 16 outputs are:
  - 5 zeros, then in0, in1;
  - 2 zeros, then in2, in3;
  - 5 zeros.
  - out_is_pad pattern 1111100110011111; out_last only on beat 16; done pulses once; in_valid high throughout but in_ready high only 4 cycles.
- Same config, out_ready toggling 1,0,0,1 repeating -> identical 16-word sequence. out_data, out_last and out_is_pad stay stable during stalls; no word is dropped or duplicated.
- Same config, in_valid low for 3 cycles before in2 -> out_valid drops for 3 cycles after in1 (bubbles). Sequence otherwise unchanged, and the counter does not skip.
- Assert rst for 1 cycle after the 7th output handshake -> out_valid=0, busy=0 and done=0 immediately. A new start produces a full, correct 16-word plane.
- start pulsed during RUN and DRAIN -> ignored (exactly 16 outputs, one done). start in the cycle after done -> second plane of 16 words, back-to-back.
- PAD=0, IMG_W=3, IMG_H=1, inputs 1,2,3 -> outputs 1,2,3 with 1-cycle latency, out_last on 3, out_is_pad always 0.
